// File: rtl/wb_stage_pipe_reg_pkg.sv
// ============================================================================
// Module : wb_stage_pipe_reg_pkg
// Brief  : Shared constants and types for the writeback-boundary pipe register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_stage_pipe_reg_pkg;

    // Forwarding source selects, as decoded by the controller from instr_o
    localparam logic [2:0] FWD_SEL_NONE   = 3'd0;
    localparam logic [2:0] FWD_SEL_CALRES = 3'd1;
    localparam logic [2:0] FWD_SEL_DMRD   = 3'd2;
    localparam logic [2:0] FWD_SEL_PC8    = 3'd3;

    // CP0 ExcCode values
    localparam logic [4:0] EXC_NONE    = 5'd0;
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    // Per-cycle update action of the stage register
    typedef enum logic [1:0] {
        LD_HOLD  = 2'd0,
        LD_LOAD  = 2'd1,
        LD_FLUSH = 2'd2
    } wb_action_e;

endpackage : wb_stage_pipe_reg_pkg

`default_nettype wire

// File: rtl/wb_stage_pipe_reg_fwd_mux.sv
// ============================================================================
// Module : wb_fwd_mux
// Brief  : Forwarding data select: 0, one of the result lanes, or PC+8.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_fwd_mux #(
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 2,
    parameter int SEL_W    = 3
) (
    input  logic [NUM_DATA*DATA_W-1:0] i_data,
    input  logic [DATA_W-1:0]          i_pc,
    input  logic [SEL_W-1:0]           i_sel,
    output logic [DATA_W-1:0]          o_fwd_data
);

    always_comb begin
        o_fwd_data = '0;
        for (int k = 0; k < NUM_DATA; k++) begin
            if (i_sel == SEL_W'(k + 1)) begin
                o_fwd_data = i_data[k*DATA_W +: DATA_W];
            end
        end
        // Link value for jal/jalr; wraps naturally at DATA_W bits
        if (i_sel == SEL_W'(NUM_DATA + 1)) begin
            o_fwd_data = i_pc + DATA_W'(8);
        end
    end

endmodule : wb_fwd_mux

`default_nettype wire

// File: rtl/wb_stage_pipe_reg.sv
// ============================================================================
// Module : wb_stage_pipe_reg
// Brief  : Writeback-boundary pipeline register with Tnew tracking, forwarding
//          bus and retire counter. Optional exception fields: WB_STAGE_EXC_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_stage_pipe_reg
    import wb_stage_pipe_reg_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 2,
    parameter int TNEW_W   = 2,
    parameter int SEL_W    = 3,
    parameter int CNT_W    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       valid_i,
    input  logic [DATA_W-1:0]          pc_i,
    input  logic [DATA_W-1:0]          instr_i,
    input  logic [NUM_DATA*DATA_W-1:0] data_i,
    input  logic                       wr_en_i,
    input  logic [4:0]                 wr_addr_i,
    input  logic [TNEW_W-1:0]          tnew_i,
    input  logic [SEL_W-1:0]           fwd_sel,
`ifdef WB_STAGE_EXC_EN
    input  logic [4:0]                 exc_code_i,
    input  logic                       bd_i,
    output logic [4:0]                 exc_code_o,
    output logic                       bd_o,
`endif
    output logic                       valid_o,
    output logic [DATA_W-1:0]          pc_o,
    output logic [DATA_W-1:0]          instr_o,
    output logic [NUM_DATA*DATA_W-1:0] data_o,
    output logic                       wr_en_o,
    output logic [4:0]                 wr_addr_o,
    output logic [TNEW_W-1:0]          tnew_o,
    output logic [DATA_W-1:0]          fwd_data,
    output logic [4:0]                 fwd_addr,
    output logic                       fwd_ready,
    output logic [CNT_W-1:0]           retire_cnt
);

    logic                       valid_q,   valid_d;
    logic [DATA_W-1:0]          pc_q,      pc_d;
    logic [DATA_W-1:0]          instr_q,   instr_d;
    logic [NUM_DATA*DATA_W-1:0] data_q,    data_d;
    logic                       wr_en_q,   wr_en_d;
    logic [4:0]                 wr_addr_q, wr_addr_d;
    logic [TNEW_W-1:0]          tnew_q,    tnew_d;
    logic [CNT_W-1:0]           retire_q,  retire_d;
    wb_action_e                 w_action;
    logic                       w_no_exc;

`ifdef WB_STAGE_EXC_EN
    logic [4:0] exc_code_q, exc_code_d;
    logic       bd_q,       bd_d;
    assign w_no_exc = (exc_code_q == EXC_NONE);
`else
    assign w_no_exc = 1'b1;
`endif

    // Flush wins over stall so a bubble can be injected into a held stage
    always_comb begin
        w_action = LD_HOLD;
        if (flush) begin
            w_action = LD_FLUSH;
        end else if (en) begin
            w_action = LD_LOAD;
        end
    end

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        data_d    = data_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        tnew_d    = (tnew_q == '0) ? '0 : tnew_q - TNEW_W'(1);
        retire_d  = retire_q;
`ifdef WB_STAGE_EXC_EN
        exc_code_d = exc_code_q;
        bd_d       = bd_q;
`endif
        case (w_action)
            LD_FLUSH: begin
                valid_d   = 1'b0;
                pc_d      = pc_i;
                instr_d   = '0;
                data_d    = '0;
                wr_en_d   = 1'b0;
                wr_addr_d = '0;
                tnew_d    = '0;
`ifdef WB_STAGE_EXC_EN
                exc_code_d = '0;
                bd_d       = 1'b0;
`endif
            end
            LD_LOAD: begin
                valid_d   = valid_i;
                pc_d      = pc_i;
                instr_d   = instr_i;
                data_d    = data_i;
                wr_en_d   = wr_en_i;
                wr_addr_d = wr_addr_i;
                tnew_d    = (tnew_i == '0) ? '0 : tnew_i - TNEW_W'(1);
`ifdef WB_STAGE_EXC_EN
                exc_code_d = exc_code_i;
                bd_d       = bd_i;
`endif
                // The held instruction retires as it leaves the stage
                if (valid_q && w_no_exc) begin
                    retire_d = retire_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            instr_q   <= '0;
            data_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            tnew_q    <= '0;
            retire_q  <= '0;
`ifdef WB_STAGE_EXC_EN
            exc_code_q <= '0;
            bd_q       <= 1'b0;
`endif
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            data_q    <= data_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            tnew_q    <= tnew_d;
            retire_q  <= retire_d;
`ifdef WB_STAGE_EXC_EN
            exc_code_q <= exc_code_d;
            bd_q       <= bd_d;
`endif
        end
    end

    wb_fwd_mux #(
        .DATA_W   (DATA_W),
        .NUM_DATA (NUM_DATA),
        .SEL_W    (SEL_W)
    ) u_fwd_mux (
        .i_data     (data_q),
        .i_pc       (pc_q),
        .i_sel      (fwd_sel),
        .o_fwd_data (fwd_data)
    );

    assign valid_o    = valid_q;
    assign pc_o       = pc_q;
    assign instr_o    = instr_q;
    assign data_o     = data_q;
    assign wr_en_o    = wr_en_q;
    assign wr_addr_o  = wr_addr_q;
    assign tnew_o     = tnew_q;
    assign retire_cnt = retire_q;
    assign fwd_addr   = (valid_q && wr_en_q) ? wr_addr_q : 5'd0;
    assign fwd_ready  = valid_q && (tnew_q == '0) && w_no_exc;
`ifdef WB_STAGE_EXC_EN
    assign exc_code_o = exc_code_q;
    assign bd_o       = bd_q;
`endif

endmodule : wb_stage_pipe_reg

`default_nettype wire

// File: tb/tb_wb_stage_pipe_reg.sv
// ============================================================================
// Module : tb_wb_stage_pipe_reg
// Brief  : Self-checking bench: vector table plus stall/flush/retire sequences.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_stage_pipe_reg;

    logic        clk = 1'b0;
    logic        reset, en, flush, valid_i, wr_en_i;
    logic [31:0] pc_i, instr_i;
    logic [63:0] data_i;
    logic [4:0]  wr_addr_i;
    logic [1:0]  tnew_i;
    logic [2:0]  fwd_sel;

    logic        valid_o, wr_en_o, fwd_ready;
    logic [31:0] pc_o, instr_o, fwd_data, retire_cnt;
    logic [63:0] data_o;
    logic [4:0]  wr_addr_o, fwd_addr;
    logic [1:0]  tnew_o;

    logic        s_valid_o, s_wr_en_o, s_fwd_ready;
    logic [31:0] s_pc_o, s_instr_o, s_fwd_data;
    logic [2:0]  s_retire_cnt;
    logic [63:0] s_data_o;
    logic [4:0]  s_wr_addr_o, s_fwd_addr;
    logic [1:0]  s_tnew_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_stage_pipe_reg dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_i(valid_i),
        .pc_i(pc_i), .instr_i(instr_i), .data_i(data_i), .wr_en_i(wr_en_i),
        .wr_addr_i(wr_addr_i), .tnew_i(tnew_i), .fwd_sel(fwd_sel),
        .valid_o(valid_o), .pc_o(pc_o), .instr_o(instr_o), .data_o(data_o),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .tnew_o(tnew_o),
        .fwd_data(fwd_data), .fwd_addr(fwd_addr), .fwd_ready(fwd_ready),
        .retire_cnt(retire_cnt)
    );

    // Narrow-counter instance sharing the same stimulus
    wb_stage_pipe_reg #(.CNT_W(3)) dut_small (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_i(valid_i),
        .pc_i(pc_i), .instr_i(instr_i), .data_i(data_i), .wr_en_i(wr_en_i),
        .wr_addr_i(wr_addr_i), .tnew_i(tnew_i), .fwd_sel(fwd_sel),
        .valid_o(s_valid_o), .pc_o(s_pc_o), .instr_o(s_instr_o), .data_o(s_data_o),
        .wr_en_o(s_wr_en_o), .wr_addr_o(s_wr_addr_o), .tnew_o(s_tnew_o),
        .fwd_data(s_fwd_data), .fwd_addr(s_fwd_addr), .fwd_ready(s_fwd_ready),
        .retire_cnt(s_retire_cnt)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] l0;
        logic [31:0] l1;
        logic        wen;
        logic [4:0]  wa;
        logic [1:0]  tnew;
        logic [2:0]  sel;
        logic [31:0] e_fd;
        logic [4:0]  e_fa;
        logic        e_rdy;
        logic [1:0]  e_tnew;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] l0, input logic [31:0] l1, input logic wen,
                        input logic [4:0] wa, input logic [1:0] tn, input logic [2:0] sel);
        valid_i = v; pc_i = pc; instr_i = ins; data_i = {l1, l0};
        wr_en_i = wen; wr_addr_i = wa; tnew_i = tn; fwd_sel = sel;
    endtask

    initial begin
        int exp_ret;
        logic prev_valid;

        // Reset with every input driven nonzero
        reset = 1'b1; en = 1'b1; flush = 1'b1;
        load(1'b1, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
             1'b1, 5'd17, 2'd3, 3'd1);
        tick();
        tick();
        chk("rst_valid", valid_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_wr", {wr_en_o, wr_addr_o}, 0);
        chk("rst_tnew", tnew_o, 0);
        chk("rst_retire", retire_cnt, 0);
        chk("rst_fwd", {fwd_data, fwd_addr, fwd_ready}, 0);

        //          valid pc            l0            l1            wen wa    tn    sel   fd            fa    rdy   tnew
        vt[0] = '{1'b1, 32'h0000_3000, 32'h0000_1234, 32'h0,        1'b1, 5'd5,  2'd0, 3'd1, 32'h0000_1234, 5'd5,  1'b1, 2'd0};
        vt[1] = '{1'b1, 32'h0000_3004, 32'h0000_AAAA, 32'hDEAD_BEEF, 1'b1, 5'd7,  2'd2, 3'd2, 32'hDEAD_BEEF, 5'd7,  1'b0, 2'd1};
        vt[2] = '{1'b1, 32'hFFFF_FFFC, 32'h1,         32'h2,        1'b0, 5'd31, 2'd1, 3'd3, 32'h0000_0004, 5'd0,  1'b1, 2'd0};
        vt[3] = '{1'b1, 32'h0000_3008, 32'h5,         32'h6,        1'b1, 5'd0,  2'd0, 3'd7, 32'h0,         5'd0,  1'b1, 2'd0};
        vt[4] = '{1'b0, 32'h0000_300C, 32'h7,         32'h8,        1'b1, 5'd9,  2'd0, 3'd0, 32'h0,         5'd0,  1'b0, 2'd0};
        vt[5] = '{1'b1, 32'h0000_3010, 32'h9,         32'hA,        1'b1, 5'd12, 2'd3, 3'd4, 32'h0,         5'd12, 1'b0, 2'd2};

        reset = 1'b0; flush = 1'b0; en = 1'b1;
        exp_ret = 0;
        prev_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            load(vt[i].valid, vt[i].pc, 32'hC0DE_0000 + i, vt[i].l0, vt[i].l1,
                 vt[i].wen, vt[i].wa, vt[i].tnew, vt[i].sel);
            if (prev_valid) exp_ret++;
            prev_valid = vt[i].valid;
            tick();
            chk($sformatf("v%0d_valid", i), valid_o, vt[i].valid);
            chk($sformatf("v%0d_pc", i), pc_o, vt[i].pc);
            chk($sformatf("v%0d_instr", i), instr_o, 32'hC0DE_0000 + i);
            chk($sformatf("v%0d_fwd_data", i), fwd_data, vt[i].e_fd);
            chk($sformatf("v%0d_fwd_addr", i), fwd_addr, vt[i].e_fa);
            chk($sformatf("v%0d_fwd_ready", i), fwd_ready, vt[i].e_rdy);
            chk($sformatf("v%0d_tnew", i), tnew_o, vt[i].e_tnew);
        end
        chk("table_retire", retire_cnt, exp_ret);

        // Load Tnew=3 then stall three cycles with garbage on the inputs
        load(1'b1, 32'h0000_4000, 32'h0C00_0001, 32'h55, 32'h66, 1'b1, 5'd3, 2'd3, 3'd1);
        exp_ret++;
        tick();
        chk("stall_load_tnew", tnew_o, 2);
        chk("stall_load_rdy", fwd_ready, 0);
        en = 1'b0;
        load(1'b0, 32'h0000_9999, 32'hFFFF_FFFF, 32'h77, 32'h88, 1'b0, 5'd30, 2'd1, 3'd1);
        for (int h = 0; h < 3; h++) begin
            tick();
            chk($sformatf("hold%0d_tnew", h), tnew_o, (h == 0) ? 1 : 0);
            chk($sformatf("hold%0d_rdy", h), fwd_ready, (h == 0) ? 1'b0 : 1'b1);
            chk($sformatf("hold%0d_payload", h), {pc_o, instr_o, fwd_data, fwd_addr},
                {32'h0000_4000, 32'h0C00_0001, 32'h55, 5'd3});
        end
        chk("hold_retire", retire_cnt, exp_ret);

        // Flush while stalled
        flush = 1'b1; pc_i = 32'h0000_3010;
        tick();
        chk("flush_valid", valid_o, 0);
        chk("flush_instr", instr_o, 0);
        chk("flush_fwd_addr", fwd_addr, 0);
        chk("flush_pc", pc_o, 32'h0000_3010);
        chk("flush_data", data_o, 0);
        chk("flush_retire", retire_cnt, exp_ret);
        flush = 1'b0;

        // Five valid loads then one extra load retires five
        reset = 1'b1;
        tick();
        reset = 1'b0; en = 1'b1;
        for (int n = 0; n < 6; n++) begin
            load(n < 5, 32'h5000 + 4 * n, 32'h1, 32'h0, 32'h0, 1'b1, 5'd1, 2'd0, 3'd0);
            tick();
        end
        chk("retire5", retire_cnt, 5);
        chk("retire5_small", s_retire_cnt, 5);

        // Nine retirements wrap the 3-bit counter to 1
        reset = 1'b1;
        tick();
        chk("midreset_retire", retire_cnt, 0);
        reset = 1'b0;
        for (int n = 0; n < 10; n++) begin
            load(1'b1, 32'h6000 + 4 * n, 32'h1, 32'h0, 32'h0, 1'b1, 5'd1, 2'd0, 3'd0);
            tick();
        end
        chk("retire9", retire_cnt, 9);
        chk("retire9_small", s_retire_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_wb_stage_pipe_reg

`default_nettype wire
